n101_subsys_ahb_bpty_chk: RTL and testbench

- Parametrised AHB bus-parity block for the n101 subsystem slave port.
- Generates per-byte read-data parity and response parity toward the master, for any DATA_W.
- Checks incoming command, address and write-data parity against a tracked AHB address/data-phase pipeline.
- Logs errors in sticky status: type, first-error address and a saturating count.

---
 rtl/n101_subsys_ahb_bpty_chk.sv | 167 ++++++++++++++++
 tb/tb_n101_subsys_ahb_bpty_chk.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n101_subsys_ahb_bpty_chk.sv
// n101_subsys_ahb_bpty_chk
//   AHB bus-parity generator/checker for the n101 subsystem slave port.
//   - Generates per-byte read-data parity (hrdatabpty) and response parity
//     (hrspbpty) combinationally.
//   - Checks command/address parity in the address phase and write-data
//     parity in the tracked data phase.
//   - Logs errors: one-cycle pulse, sticky flag, sticky type, first-error
//     address and a saturating error-cycle counter. err_clr clears status.
//   Parity rule: expected bit = XOR(covered bits) ^ bptylvl.
//   Optional build macro N101_BPTY_ERR_INJ_EN adds input bpty_inj, a one-shot
//   inversion of hrdatabpty[0]/hrspbpty on the next hready=1 cycle.
// Ports:
//   clk, rst (async, active-high), bptylvl
//   AHB: htrans, hsize, hburst, hprot, hwrite, hmastlock, master, haddr,
//        hwdata, hrdata, hresp, hready
//   parity in : hcmdbpty, haddrbpty, hwdatabpty
//   parity out: hrdatabpty, hrspbpty
//   status    : err_clr, bpty_err, bpty_err_sticky, err_type, err_addr, err_cnt
module n101_subsys_ahb_bpty_chk #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_W    = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bptylvl,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hsize,
  input  logic [2:0]             hburst,
  input  logic [3:0]             hprot,
  input  logic                   hwrite,
  input  logic                   hmastlock,
  input  logic [1:0]             master,
  input  logic [ADDR_SIZE-1:0]   haddr,
  input  logic [DATA_W-1:0]      hwdata,
  input  logic [DATA_W-1:0]      hrdata,
  input  logic [1:0]             hresp,
  input  logic                   hready,
  input  logic [1:0]             hcmdbpty,
  input  logic [ADDR_SIZE/8-1:0] haddrbpty,
  input  logic [DATA_W/8-1:0]    hwdatabpty,
  output logic [DATA_W/8-1:0]    hrdatabpty,
  output logic                   hrspbpty,
  input  logic                   err_clr,
`ifdef N101_BPTY_ERR_INJ_EN
  input  logic                   bpty_inj,
`endif
  output logic                   bpty_err,
  output logic                   bpty_err_sticky,
  output logic [2:0]             err_type,
  output logic [ADDR_SIZE-1:0]   err_addr,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  localparam int AB = ADDR_SIZE / 8;
  localparam int DB = DATA_W / 8;

  logic [DB-1:0]        rd_par;
  logic [DB-1:0]        wd_exp;
  logic [AB-1:0]        ad_exp;
  logic [1:0]           cmd_exp;
  logic                 aph;
  logic                 e_cmd;
  logic                 e_adr;
  logic                 e_wd;
  logic                 any_err;
  logic [2:0]           new_type;
  logic [ADDR_SIZE-1:0] src_addr;
  logic                 inj_now;

  logic                 dph_vld;
  logic                 dph_wr;
  logic [ADDR_SIZE-1:0] dph_addr;

  always_comb begin
    rd_par = '0;
    wd_exp = '0;
    ad_exp = '0;
    for (int unsigned i = 0; i < DB; i++) begin
      rd_par[i] = (^hrdata[8*i +: 8]) ^ bptylvl;
      wd_exp[i] = (^hwdata[8*i +: 8]) ^ bptylvl;
    end
    for (int unsigned i = 0; i < AB; i++) begin
      ad_exp[i] = (^haddr[8*i +: 8]) ^ bptylvl;
    end
    cmd_exp[0] = (^{htrans, hsize, hburst}) ^ bptylvl;
    cmd_exp[1] = (^{hprot, hwrite, hmastlock, master}) ^ bptylvl;
  end

  assign aph      = hready & htrans[1];
  assign e_cmd    = aph & (hcmdbpty != cmd_exp);
  assign e_adr    = aph & (haddrbpty != ad_exp);
  assign e_wd     = dph_vld & dph_wr & hready & (hwdatabpty != wd_exp);
  assign any_err  = e_cmd | e_adr | e_wd;
  assign new_type = {e_wd, e_adr, e_cmd};
  // A data-phase error belongs to the older transfer, so its address wins.
  assign src_addr = e_wd ? dph_addr : haddr;

`ifdef N101_BPTY_ERR_INJ_EN
  logic inj_armed;

  // Once armed, further pulses are ignored until the inversion is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_armed <= 1'b0;
    end else if (inj_armed) begin
      inj_armed <= ~hready;
    end else begin
      inj_armed <= bpty_inj;
    end
  end

  assign inj_now = inj_armed & hready;
`else
  assign inj_now = 1'b0;
`endif

  always_comb begin
    hrdatabpty    = rd_par;
    hrdatabpty[0] = rd_par[0] ^ inj_now;
    hrspbpty      = (^{hresp, hready}) ^ bptylvl ^ inj_now;
  end

  // Data-phase tracker: holds across wait states (hready=0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dph_vld  <= 1'b0;
      dph_wr   <= 1'b0;
      dph_addr <= '0;
    end else if (aph) begin
      dph_vld  <= 1'b1;
      dph_wr   <= hwrite;
      dph_addr <= haddr;
    end else if (hready) begin
      dph_vld  <= 1'b0;
    end
  end

  // Error status. A clear coinciding with an error logs that error afresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bpty_err        <= 1'b0;
      bpty_err_sticky <= 1'b0;
      err_type        <= '0;
      err_addr        <= '0;
      err_cnt         <= '0;
    end else begin
      bpty_err <= any_err;
      if (err_clr) begin
        bpty_err_sticky <= any_err;
        err_type        <= new_type;
        err_cnt         <= any_err ? ERR_CNT_W'(1) : '0;
        err_addr        <= any_err ? src_addr : '0;
      end else if (any_err) begin
        bpty_err_sticky <= 1'b1;
        err_type        <= err_type | new_type;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
        if (!bpty_err_sticky) begin
          err_addr <= src_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_n101_subsys_ahb_bpty_chk.sv
module tb_n101_subsys_ahb_bpty_chk;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bptylvl = 1'b0;
  logic [1:0]    htrans = '0;
  logic [2:0]    hsize = '0;
  logic [2:0]    hburst = '0;
  logic [3:0]    hprot = '0;
  logic          hwrite = 1'b0;
  logic          hmastlock = 1'b0;
  logic [1:0]    master = '0;
  logic [AW-1:0] haddr = '0;
  logic [DW-1:0] hwdata = '0;
  logic [DW-1:0] hrdata = '0;
  logic [1:0]    hresp = '0;
  logic          hready = 1'b1;
  logic [1:0]    hcmdbpty = '0;
  logic [3:0]    haddrbpty = '0;
  logic [3:0]    hwdatabpty = '0;
  logic          err_clr = 1'b0;
  logic          bpty_inj = 1'b0;
  logic [3:0]    hrdatabpty;
  logic          hrspbpty;
  logic          bpty_err;
  logic          bpty_err_sticky;
  logic [2:0]    err_type;
  logic [AW-1:0] err_addr;
  logic [CW-1:0] err_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  n101_subsys_ahb_bpty_chk #(.ADDR_SIZE(AW), .DATA_W(DW), .ERR_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bptylvl(bptylvl), .htrans(htrans), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hwrite(hwrite), .hmastlock(hmastlock),
    .master(master), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata),
    .hresp(hresp), .hready(hready), .hcmdbpty(hcmdbpty), .haddrbpty(haddrbpty),
    .hwdatabpty(hwdatabpty), .hrdatabpty(hrdatabpty), .hrspbpty(hrspbpty),
    .err_clr(err_clr),
`ifdef N101_BPTY_ERR_INJ_EN
    .bpty_inj(bpty_inj),
`endif
    .bpty_err(bpty_err), .bpty_err_sticky(bpty_err_sticky), .err_type(err_type),
    .err_addr(err_addr), .err_cnt(err_cnt)
  );

  // ---------------- reference model ----------------
  // Parity by counting ones: odd count -> 1, then inverted for odd level.
  function automatic logic podd(input logic [63:0] v, input int n, input logic lvl);
    int ones = 0;
    for (int i = 0; i < n; i++) if (v[i]) ones++;
    return logic'(ones % 2) ^ lvl;
  endfunction

  function automatic logic [3:0] bytepar(input logic [31:0] v, input logic lvl);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = podd(64'(v >> (8*b)), 8, lvl);
    return r;
  endfunction

  function automatic logic [1:0] cmdpar(input logic [1:0] tr, input logic [2:0] sz,
                                        input logic [2:0] bu, input logic [3:0] pr,
                                        input logic wr, input logic lk,
                                        input logic [1:0] ms, input logic lvl);
    return {podd(64'({pr, wr, lk, ms}), 8, lvl), podd(64'({tr, sz, bu}), 8, lvl)};
  endfunction

  logic          m_pend, m_pend_wr;
  logic [AW-1:0] m_pend_addr;
  logic          m_pulse, m_sticky;
  logic [2:0]    m_type;
  logic [AW-1:0] m_eaddr;
  int            m_cnt;
  logic          m_armed;
  logic          m_ec, m_ea, m_ew, m_any, m_inj;
  logic [3:0]    m_rd;
  logic          m_rsp;

  always_comb begin
    m_ec  = hready && htrans[1] &&
            (hcmdbpty != cmdpar(htrans, hsize, hburst, hprot, hwrite, hmastlock, master, bptylvl));
    m_ea  = hready && htrans[1] && (haddrbpty != bytepar(haddr, bptylvl));
    m_ew  = m_pend && m_pend_wr && hready && (hwdatabpty != bytepar(hwdata, bptylvl));
    m_any = m_ec || m_ea || m_ew;
    m_inj = m_armed && hready;
    m_rd  = bytepar(hrdata, bptylvl) ^ {3'b000, m_inj};
    m_rsp = podd(64'({hresp, hready}), 3, bptylvl) ^ m_inj;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 1'b0; m_pend_wr <= 1'b0; m_pend_addr <= '0;
      m_pulse <= 1'b0; m_sticky <= 1'b0; m_type <= '0; m_eaddr <= '0; m_cnt <= 0;
      m_armed <= 1'b0;
    end else begin
      if (hready && htrans[1]) begin
        m_pend <= 1'b1; m_pend_wr <= hwrite; m_pend_addr <= haddr;
      end else if (hready) begin
        m_pend <= 1'b0;
      end
      m_pulse <= m_any;
      if (err_clr) begin
        m_sticky <= m_any;
        m_type   <= {m_ew, m_ea, m_ec};
        m_cnt    <= m_any ? 1 : 0;
        m_eaddr  <= m_any ? (m_ew ? m_pend_addr : haddr) : '0;
      end else if (m_any) begin
        m_sticky <= 1'b1;
        m_type   <= m_type | {m_ew, m_ea, m_ec};
        m_cnt    <= (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        if (!m_sticky) m_eaddr <= m_ew ? m_pend_addr : haddr;
      end
`ifdef N101_BPTY_ERR_INJ_EN
      if (m_armed) m_armed <= !hready;
      else         m_armed <= bpty_inj;
`endif
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("hrdatabpty", 64'(hrdatabpty), 64'(m_rd));
      check("hrspbpty", 64'(hrspbpty), 64'(m_rsp));
      check("bpty_err", 64'(bpty_err), 64'(m_pulse));
      check("sticky", 64'(bpty_err_sticky), 64'(m_sticky));
      check("err_type", 64'(err_type), 64'(m_type));
      check("err_addr", 64'(err_addr), 64'(m_eaddr));
      check("err_cnt", 64'(err_cnt), 64'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic setgood();
    hcmdbpty   = cmdpar(htrans, hsize, hburst, hprot, hwrite, hmastlock, master, bptylvl);
    haddrbpty  = bytepar(haddr, bptylvl);
    hwdatabpty = bytepar(hwdata, bptylvl);
  endtask

  task automatic idle();
    htrans = 2'b00; hwrite = 1'b0; err_clr = 1'b0; hready = 1'b1; bpty_inj = 1'b0;
    setgood();
  endtask

  task automatic clear();
    idle(); err_clr = 1'b1; cyc(); err_clr = 1'b0;
  endtask

  task automatic status(input string tag, input logic [2:0] ty, input logic [31:0] ad,
                        input int cnt);
    @(negedge clk);
    check({tag, "_type"}, 64'(err_type), 64'(ty));
    check({tag, "_addr"}, 64'(err_addr), 64'(ad));
    check({tag, "_cnt"}, 64'(err_cnt), 64'(cnt));
  endtask

  initial begin
    idle();
    cyc(); cyc();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_err", 64'(bpty_err), 64'd0);
    check("rst_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;
    cyc();

    // Read-data / response parity, both levels.
    hrdata = 32'h0000_0103; hresp = 2'b00; hready = 1'b1; setgood();
    @(negedge clk);
    check("rd_even", 64'(hrdatabpty), 64'b0010);
    check("rsp_even", 64'(hrspbpty), 64'd1);
    bptylvl = 1'b1; setgood(); #1;
    check("rd_odd", 64'(hrdatabpty), 64'b1101);
    check("rsp_odd", 64'(hrspbpty), 64'd0);
    cyc();
    bptylvl = 1'b0; setgood(); cyc();

    // Write data error on byte 2.
    haddr = 32'h2000_0010; htrans = 2'b10; hwrite = 1'b1; setgood(); cyc();
    idle(); haddr = '0; hwdata = 32'hA5A5_A5A5; setgood(); hwdatabpty ^= 4'b0100; cyc();
    idle();
    @(negedge clk);
    check("wd_pulse", 64'(bpty_err), 64'd1);
    check("wd_sticky", 64'(bpty_err_sticky), 64'd1);
    status("wd", 3'b100, 32'h2000_0010, 1);
    cyc();
    @(negedge clk);
    check("wd_pulse_end", 64'(bpty_err), 64'd0);
    clear();

    // Bad address parity held through wait states: logged once.
    haddr = 32'h1234_5678; htrans = 2'b10; hwrite = 1'b0; hready = 1'b0; setgood();
    haddrbpty ^= 4'b1000;
    repeat (3) cyc();
    hready = 1'b1; cyc();
    idle();
    status("hold", 3'b010, 32'h1234_5678, 1);
    for (int t = 0; t < 2; t++) begin
      htrans = 2'(t); haddr = 32'h0BAD_0000; setgood();
      hcmdbpty ^= 2'b11; haddrbpty ^= 4'b0001; cyc();
    end
    idle();
    status("idlebusy", 3'b010, 32'h1234_5678, 1);
    clear();

    // Same-cycle data-phase and address-phase errors.
    haddr = 32'h100; htrans = 2'b10; hwrite = 1'b1; setgood(); cyc();
    haddr = 32'h104; htrans = 2'b11; hwrite = 1'b0; hwdata = 32'h1122_3344; setgood();
    haddrbpty ^= 4'b0001; hwdatabpty ^= 4'b0001; cyc();
    idle();
    status("b2b", 3'b110, 32'h100, 1);
    haddr = 32'h200; htrans = 2'b10; setgood(); hcmdbpty ^= 2'b01; cyc();
    idle();
    status("cmd2", 3'b111, 32'h100, 2);
    clear();

    // Counter saturation, then clear with a simultaneous error.
    for (int k = 0; k < 5; k++) begin
      haddr = 32'h300 + 32'(4*k); htrans = 2'b10; setgood(); hcmdbpty ^= 2'b10; cyc();
    end
    idle();
    status("sat", 3'b001, 32'h300, 3);
    err_clr = 1'b1; haddr = 32'h400; htrans = 2'b10; setgood(); hcmdbpty ^= 2'b10; cyc();
    idle();
    status("clr_err", 3'b001, 32'h400, 1);
    clear();

    // Mixed traffic at both levels, checked by the model every cycle.
    for (int k = 0; k < 60; k++) begin
      bptylvl = k[3]; htrans = 2'($urandom); hsize = 3'($urandom); hburst = 3'($urandom);
      hprot = 4'($urandom); hwrite = 1'($urandom); hmastlock = 1'($urandom);
      master = 2'($urandom); haddr = $urandom; hwdata = $urandom; hrdata = $urandom;
      hresp = 2'($urandom); hready = ($urandom_range(0, 3) != 0);
      err_clr = ($urandom_range(0, 9) == 0);
      setgood();
      if ($urandom_range(0, 3) == 0) hcmdbpty ^= 2'($urandom);
      if ($urandom_range(0, 3) == 0) haddrbpty ^= 4'($urandom);
      if ($urandom_range(0, 3) == 0) hwdatabpty ^= 4'($urandom);
      cyc();
    end
    bptylvl = 1'b0; hresp = 2'b00; clear();

    // Reset with a write data phase pending: that data phase is not checked.
    haddr = 32'h500; htrans = 2'b10; hwrite = 1'b1; setgood(); cyc();
    idle(); hwdata = 32'h0000_00FF; setgood(); hwdatabpty ^= 4'b0001;
    #2 rst = 1'b1;
    cyc(); rst = 1'b0; cyc();
    idle();
    @(negedge clk);
    check("rst_pend_sticky", 64'(bpty_err_sticky), 64'd0);
    check("rst_pend_cnt", 64'(err_cnt), 64'd0);

`ifdef N101_BPTY_ERR_INJ_EN
    hrdata = 32'h0000_0103; hresp = 2'b00;
    bpty_inj = 1'b1; hready = 1'b0; cyc();
    bpty_inj = 1'b0; cyc();
    hready = 1'b1;
    @(negedge clk);
    check("inj_rd", 64'(hrdatabpty), 64'b0011);
    check("inj_rsp", 64'(hrspbpty), 64'd0);
    cyc();
    @(negedge clk);
    check("inj_done_rd", 64'(hrdatabpty), 64'b0010);
    check("inj_done_rsp", 64'(hrspbpty), 64'd1);
    bpty_inj = 1'b1; hready = 1'b0; cyc();
    bpty_inj = 1'b0; #2 rst = 1'b1; cyc(); rst = 1'b0; hready = 1'b1;
    @(negedge clk);
    check("inj_rst_rd", 64'(hrdatabpty), 64'b0010);
    cyc();
`endif

    idle(); cyc(); cyc();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
